// File: rtl/adc_emu_pkg.sv
// Shared constants for the ADC emulator: command frame field positions,
// mode register bit assignments and the conversion FSM state type.
package adc_emu_pkg;

  localparam int CMD_RW_BIT   = 23;
  localparam int CMD_ADDR_MSB = 22;
  localparam int CMD_ADDR_LSB = 8;
  localparam int CMD_DATA_MSB = 7;
  localparam int CMD_DATA_LSB = 0;

  localparam int MODE_TP_BIT  = 0;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } conv_state_e;

endpackage

// File: rtl/adc_emu_sync.sv
// 2-FF synchroniser for one asynchronous SPI pin, plus single-cycle
// rise/fall pulses derived from the synchronised value.
module adc_emu_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign dout = s2;
  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

endmodule

// File: rtl/adc_emulator.sv
// SPI responder model of a multi-lane ADC fed by an AXI-Stream sample source.
// Optional internal counting test pattern: define ADC_EMU_TEST_PATTERN_EN.
module adc_emulator
  import adc_emu_pkg::*;
#(
  parameter int          NUM_SDI     = 4,
  parameter int          DATA_WIDTH  = 24,
  parameter int          CMD_WIDTH   = 24,
  parameter int          CONV_CYCLES = 40,
  parameter logic [14:0] MODE_ADDR   = 15'h0020
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               spi_cnv,
  input  logic               spi_csn,
  input  logic               spi_sck,
  input  logic               spi_sdi,
  output logic [NUM_SDI-1:0] spi_sdo,
  output logic               busy,
  input  logic [31:0]        s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic [7:0]         cfg_mode,
  output logic               underflow
);

  localparam int CW    = $clog2(CONV_CYCLES + 1);
  localparam int CNT_W = $clog2(CMD_WIDTH + 2);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(CONV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CMD_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CMD_WIDTH);

  // pin index: 3 cnv, 2 csn, 1 sck, 0 sdi
  logic [3:0] sy, ry, fy;

  adc_emu_sync u_sync [3:0] (
    .clk  (aclk),
    .rst  (areset),
    .din  ({spi_cnv, spi_csn, spi_sck, spi_sdi}),
    .dout (sy),
    .rise (ry),
    .fall (fy)
  );

  logic cnv_rise, csn_rise, csn_fall, sck_rise, sck_fall, sdi_s;
  assign cnv_rise = ry[3];
  assign csn_rise = ry[2];
  assign csn_fall = fy[2];
  assign sck_rise = ry[1];
  assign sck_fall = fy[1];
  assign sdi_s    = sy[0];

  logic unused;
  assign unused = &{1'b0, sy[3:1], ry[0], fy[3], fy[0], s_axis_tdata[31:DATA_WIDTH]};

  conv_state_e state, next_state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] pending, held;
  logic                  accept;

  logic                  use_tp;
  logic [DATA_WIDTH-1:0] tp_val;

`ifdef ADC_EMU_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] tp_cnt;
  assign use_tp = cfg_mode[MODE_TP_BIT];
  assign tp_val = tp_cnt;

  always_ff @(posedge aclk) begin
    if (areset)               tp_cnt <= '0;
    else if (accept && use_tp) tp_cnt <= tp_cnt + 1'b1;
  end
`else
  assign use_tp = 1'b0;
  assign tp_val = '0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE:    if (cnv_rise) begin
                 next_state = CONVERT;
                 accept     = 1'b1;
               end
      CONVERT: if (cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy          = (state == CONVERT);
  assign s_axis_tready = accept & ~use_tp & s_axis_tvalid & ~areset;

  always_ff @(posedge aclk) begin
    if (areset) begin
      cnt       <= '0;
      pending   <= '0;
      held      <= '0;
      underflow <= 1'b0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
      if (use_tp)             pending <= tp_val;
      else if (s_axis_tvalid) pending <= s_axis_tdata[DATA_WIDTH-1:0];
      else begin
        // starved stream: repeat the last sample and flag it
        pending   <= held;
        underflow <= 1'b1;
      end
    end else if (state == CONVERT) begin
      if (cnt == '0) held <= pending;
      else           cnt  <= cnt - 1'b1;
    end
  end

  logic [DATA_WIDTH-1:0] sr;
  logic [CMD_WIDTH-1:0]  cmd_sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  frame_act;
  logic                  wr_ok;

  assign wr_ok = frame_act && (bit_cnt == CNT_FULL) && !cmd_sr[CMD_RW_BIT] &&
                 (cmd_sr[CMD_ADDR_MSB:CMD_ADDR_LSB] == MODE_ADDR);

  // frame_act keeps SCK edges from acting outside a CSN fall..rise window,
  // including a frame that was cut short by reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      sr        <= '0;
      cmd_sr    <= '0;
      bit_cnt   <= '0;
      frame_act <= 1'b0;
      cfg_mode  <= 8'h00;
    end else if (csn_fall) begin
      sr        <= held;
      cmd_sr    <= '0;
      bit_cnt   <= '0;
      frame_act <= 1'b1;
    end else if (csn_rise) begin
      sr        <= '0;
      frame_act <= 1'b0;
      if (wr_ok) cfg_mode <= cmd_sr[CMD_DATA_MSB:CMD_DATA_LSB];
    end else if (frame_act) begin
      if (sck_fall) sr <= {sr[DATA_WIDTH-NUM_SDI-1:0], {NUM_SDI{1'b0}}};
      if (sck_rise) begin
        cmd_sr <= {cmd_sr[CMD_WIDTH-2:0], sdi_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign spi_sdo = sr[DATA_WIDTH-1 -: NUM_SDI];

endmodule

// File: tb/tb_adc_emulator.sv
// Directed plus randomized bench for adc_emulator with a behavioural model
// of held sample, mode register, underflow and the optional test pattern.
module tb_adc_emulator;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        spi_cnv = 1'b0, spi_csn = 1'b1, spi_sck = 1'b0, spi_sdi = 1'b0;
  logic [3:0]  spi_sdo;
  logic        busy;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  cfg_mode;
  logic        underflow;

  adc_emulator dut (
    .aclk          (aclk),
    .areset        (areset),
    .spi_cnv       (spi_cnv),
    .spi_csn       (spi_csn),
    .spi_sck       (spi_sck),
    .spi_sdi       (spi_sdi),
    .spi_sdo       (spi_sdo),
    .busy          (busy),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .cfg_mode      (cfg_mode),
    .underflow     (underflow)
  );

  always #5 aclk = ~aclk;

  int ncmp = 0, nfail = 0;
  int tready_cnt = 0, busy_cnt = 0;

  always @(negedge aclk) begin
    if (s_axis_tready === 1'b1) tready_cnt++;
    if (busy === 1'b1)          busy_cnt++;
  end

  logic [23:0] m_held = '0, m_tp = '0;
  logic [7:0]  m_cfg = '0;
  logic        m_uf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_held = '0; m_tp = '0; m_cfg = '0; m_uf = 1'b0;
  endtask

  task automatic pulse_cnv();
    spi_cnv = 1'b1; #30; spi_cnv = 1'b0;
  endtask

  // one conversion; optionally a second CNV 10 cycles into the busy window
  task automatic convert(input logic valid, input logic [31:0] data, input logic second);
    int t0, b0, n;
    logic [23:0] exp_s;
    int exp_tr;
    t0 = tready_cnt; b0 = busy_cnt;
    s_axis_tdata = data; s_axis_tvalid = valid;
    pulse_cnv();
    n = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge aclk); n++; end
    if (second) begin
      repeat (10) @(negedge aclk);
      pulse_cnv();
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin @(negedge aclk); n++; end
    chk("busy_drop", busy, 1'b0);
    s_axis_tvalid = 1'b0;
    exp_tr = 0;
    exp_s  = m_held;
`ifdef ADC_EMU_TEST_PATTERN_EN
    if (m_cfg[0]) begin
      exp_s = m_tp; m_tp = m_tp + 1;
    end else
`endif
    if (valid) begin
      exp_s = data[23:0]; exp_tr = 1;
    end else m_uf = 1'b1;
    m_held = exp_s;
    chk("busy_cycles", busy_cnt - b0, 40);
    chk("tready_pulses", tready_cnt - t0, exp_tr);
    chk("underflow", underflow, m_uf);
  endtask

  // frame of nsck clocks sending cmd MSB-first; returns the first 6 nibbles read
  task automatic frame(input int nsck, input logic [23:0] cmd, output logic [23:0] rd);
    rd = '0;
    spi_csn = 1'b0; #40;
    for (int i = 0; i < nsck; i++) begin
      spi_sdi = (i < 24) ? cmd[23-i] : 1'b0;
      #40;
      @(negedge aclk);
      if (i < 6) rd[23-4*i -: 4] = spi_sdo;
      spi_sck = 1'b1; #40;
      spi_sck = 1'b0; #40;
    end
    #40;
    @(negedge aclk);
    if (nsck >= 6) chk("lanes_drained", spi_sdo, 4'h0);
    spi_csn = 1'b1; spi_sdi = 1'b0;
    repeat (5) @(negedge aclk);
    chk("sdo_idle", spi_sdo, 4'h0);
    if (nsck == 24 && !cmd[23] && cmd[22:8] == 15'h0020) m_cfg = cmd[7:0];
    chk("cfg_mode", cfg_mode, m_cfg);
  endtask

  initial begin
    logic [23:0] rd;
    logic [23:0] cmd;
    int ns;

    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    model_reset();
    @(negedge aclk);
    chk("rst_sdo", spi_sdo, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_cfg", cfg_mode, 8'h00);
    chk("rst_uf", underflow, 1'b0);

    // basic conversion and 6-clock readout
    convert(1'b1, 32'h00ABCDEF, 1'b0);
    frame(6, 24'h0, rd);
    chk("read_abcdef", rd, 24'hABCDEF);
    chk("read_model", rd, m_held);

    // mode register writes: good, short, wrong address
    frame(24, 24'h002001, rd);
    chk("cfg_written", cfg_mode, 8'h01);
    frame(23, 24'h002055, rd);
    frame(24, 24'h002155, rd);
    frame(24, 24'h802077, rd);
    frame(24, 24'h002000, rd);

    // underflow repeats the previous sample
    convert(1'b1, 32'hFF123456, 1'b0);
    convert(1'b0, 32'h00999999, 1'b0);
    frame(6, 24'h0, rd);
    chk("uf_repeat", rd, m_held);

    // second CNV during conversion is ignored
    convert(1'b1, 32'h00654321, 1'b1);
    frame(6, 24'h0, rd);
    chk("ignored_cnv", rd, m_held);

    // reset in the middle of a frame that overlaps a conversion
    s_axis_tdata = 32'h00777777; s_axis_tvalid = 1'b1;
    pulse_cnv();
    spi_csn = 1'b0; #40;
    for (int i = 0; i < 3; i++) begin
      spi_sck = 1'b1; #40; spi_sck = 1'b0; #40;
    end
    @(posedge aclk); #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    model_reset();
    @(negedge aclk);
    chk("rst_mid_sdo", spi_sdo, 4'h0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_uf", underflow, 1'b0);
    chk("rst_mid_cfg", cfg_mode, 8'h00);
    s_axis_tvalid = 1'b0;
    spi_csn = 1'b1;
    repeat (5) @(negedge aclk);
    frame(6, 24'h0, rd);
    chk("post_rst_read", rd, 24'h000000);

    // randomized conversions, reads and command frames
    for (int k = 0; k < 8; k++) begin
      convert(($urandom_range(0, 3) != 0), $urandom, 1'b0);
      frame(6, 24'h0, rd);
      chk("rand_read", rd, m_held);
      ns = 23 + $urandom_range(0, 2);
      cmd[23]   = ($urandom_range(0, 3) == 0);
      cmd[22:8] = ($urandom_range(0, 1) == 0) ? 15'h0020 : 15'($urandom);
      cmd[7:0]  = 8'($urandom);
      frame(ns, cmd, rd);
      chk("rand_read_wr", rd, m_held);
    end

`ifdef ADC_EMU_TEST_PATTERN_EN
    frame(24, 24'h002001, rd);
    for (int k = 0; k < 3; k++) begin
      convert(1'b1, $urandom, 1'b0);
      frame(6, 24'h0, rd);
      chk("tp_read", rd, m_held);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
